// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the two-digit BCD countdown timer: state encoding,
// 7-segment glyphs and BCD helper functions.
package countdown_timer_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Active-high segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Saturate each digit of a two-digit BCD value at 9
  function automatic logic [7:0] bcdClamp(input logic [7:0] value);
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
    tens = (value[7:4] > 4'd9) ? 4'd9 : value[7:4];
    ones = (value[3:0] > 4'd9) ? 4'd9 : value[3:0];
    return {tens, ones};
  endfunction

  // Subtract one from a two-digit BCD value; 00 stays 00
  function automatic logic [7:0] bcdDecrement(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'h00) begin
      result = 8'h00;
    end else if (value[3:0] == 4'd0) begin
      result = {value[7:4] - 4'd1, 4'd9};
    end else begin
      result = {value[7:4], value[3:0] - 4'd1};
    end
    return result;
  endfunction

endpackage

// File: rtl/countdown_timer_seg7.sv
// Combinational BCD digit to active-high 7-segment decoder; non-BCD inputs blank.
module bcd_seg7_decoder
  import countdown_timer_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [6:0]         seg_o
);

  // Look up the glyph for the digit, blanking anything above 9
  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable two-digit BCD countdown timer with built-in prescaler and a
// multiplexed two-digit 7-segment display driver.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int TICK_DIV       = 50,
  parameter int SCAN_DIV       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       I_CLK,
  input  logic       Rst,
  input  logic       iLoad,
  input  logic [7:0] iValue,
  input  logic       iStart,
  input  logic       iPause,
  output logic [7:0] oQ,
  output logic       oBusy,
  output logic       oDone,
  output logic [6:0] oDisplay,
  output logic [1:0] oDigitSel
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [6:0]    SEG_RESET  = SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;

  state_e        state_q;
  logic [7:0]    count_q;
  logic [7:0]    countDec;
  logic [PW-1:0] presc_q;
  logic          busy_q;
  logic          done_q;

  logic [SW-1:0]      scanCnt_q;
  logic [SW-1:0]      scanCnt_d;
  logic [1:0]         digitSel_q;
  logic [1:0]         digitSel_d;
  logic [6:0]         display_q;
  logic [DIGIT_W-1:0] scanDigit;
  logic [6:0]         segRaw;
  logic [6:0]         segPol;

  assign countDec = bcdDecrement(count_q);

  // Control FSM: loading, start/pause/resume, prescaled decrement and completion pulse
  always_ff @(posedge I_CLK) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      count_q <= 8'h00;
      presc_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iLoad) begin
            count_q <= bcdClamp(iValue);
          end else if (iStart) begin
            if (count_q != 8'h00) begin
              state_q <= ST_RUN;
              presc_q <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (iPause) begin
            state_q <= ST_PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            count_q <= countDec;
            if (countDec == 8'h00) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (iLoad) begin
            count_q <= bcdClamp(iValue);
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (iStart) begin
            state_q <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (iLoad) begin
            count_q <= bcdClamp(iValue);
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Next scan position: the digit select flips each time the scan counter wraps
  always_comb begin
    scanCnt_d  = scanCnt_q + SW'(1);
    digitSel_d = digitSel_q;
    if (scanCnt_q == SCAN_LAST) begin
      scanCnt_d  = '0;
      digitSel_d = {digitSel_q[0], digitSel_q[1]};
    end
  end

  assign scanDigit = digitSel_d[0] ? count_q[3:0] : count_q[7:4];

  bcd_seg7_decoder uDecoder (
    .digit_i (scanDigit),
    .seg_o   (segRaw)
  );

  assign segPol = SEG_ACTIVE_LOW ? ~segRaw : segRaw;

  // Display scan registers: digit select and its glyph change together on the same edge
  always_ff @(posedge I_CLK) begin
    if (Rst) begin
      scanCnt_q  <= '0;
      digitSel_q <= 2'b01;
      display_q  <= SEG_RESET;
    end else begin
      scanCnt_q  <= scanCnt_d;
      digitSel_q <= digitSel_d;
      display_q  <= segPol;
    end
  end

  assign oQ        = count_q;
  assign oBusy     = busy_q;
  assign oDone     = done_q;
  assign oDisplay  = display_q;
  assign oDigitSel = digitSel_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios followed by
// random stimulus, compared every cycle against a decimal-arithmetic model.
module tb_countdown_timer;

  localparam int TICK = 4;
  localparam int SCAN = 2;

  logic       I_CLK = 1'b0;
  logic       Rst = 1'b0;
  logic       iLoad = 1'b0;
  logic [7:0] iValue = 8'h00;
  logic       iStart = 1'b0;
  logic       iPause = 1'b0;
  logic [7:0] oQ;
  logic       oBusy;
  logic       oDone;
  logic [6:0] oDisplay;
  logic [1:0] oDigitSel;

  int checks = 0;
  int failures = 0;

  // Model: mode 0 idle, 1 counting, 2 held, 3 finished; count is a plain integer 0..99
  int mMode = 0;
  int mCount = 0;
  int mPhase = 0;
  int mEdges = 0;
  bit mBusy = 1'b0;
  bit mDone = 1'b0;
  logic [6:0] mDisp = 7'h3F;
  logic [1:0] mSel = 2'b01;

  logic [6:0] segTable [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  countdown_timer #(
    .TICK_DIV       (TICK),
    .SCAN_DIV       (SCAN),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .I_CLK     (I_CLK),
    .Rst       (Rst),
    .iLoad     (iLoad),
    .iValue    (iValue),
    .iStart    (iStart),
    .iPause    (iPause),
    .oQ        (oQ),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oDisplay  (oDisplay),
    .oDigitSel (oDigitSel)
  );

  // Free-running board clock
  always #5 I_CLK = ~I_CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h at time %0t",
               tag, observed, expected, $time);
    end
  endtask

  function automatic int toBcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  function automatic int clampLoad(input logic [7:0] v);
    int t;
    int o;
    t = int'(v[7:4]);
    o = int'(v[3:0]);
    if (t > 9) t = 9;
    if (o > 9) o = 9;
    return t * 10 + o;
  endfunction

  task automatic modelEdge(input bit rst, input bit ld, input logic [7:0] val,
                           input bit st, input bit pa);
    int prev;
    prev = mCount;
    if (rst) begin
      mMode  = 0;
      mCount = 0;
      mPhase = 0;
      mEdges = 0;
      mDone  = 1'b0;
      mSel   = 2'b01;
      mDisp  = 7'h3F;
    end else begin
      mEdges++;
      mDone = 1'b0;
      mSel  = (((mEdges / SCAN) % 2) == 1) ? 2'b10 : 2'b01;
      mDisp = (mSel == 2'b10) ? segTable[prev / 10] : segTable[prev % 10];
      case (mMode)
        0: begin
          if (ld) mCount = clampLoad(val);
          else if (st) begin
            if (mCount != 0) begin
              mMode  = 1;
              mPhase = 0;
            end else begin
              mMode = 3;
              mDone = 1'b1;
            end
          end
        end
        1: begin
          if (pa) mMode = 2;
          else if (mPhase == TICK - 1) begin
            mPhase = 0;
            mCount = mCount - 1;
            if (mCount == 0) begin
              mMode = 3;
              mDone = 1'b1;
            end
          end else mPhase++;
        end
        2: begin
          if (ld) begin
            mCount = clampLoad(val);
            mMode  = 0;
          end else if (st) mMode = 1;
        end
        default: begin
          if (ld) begin
            mCount = clampLoad(val);
            mMode  = 0;
          end
        end
      endcase
    end
    mBusy = (mMode == 1) || (mMode == 2);
  endtask

  task automatic applyStimulus(input bit rst, input bit ld, input logic [7:0] val,
                               input bit st, input bit pa);
    @(negedge I_CLK);
    Rst    = rst;
    iLoad  = ld;
    iValue = val;
    iStart = st;
    iPause = pa;
    @(posedge I_CLK);
    #1;
    modelEdge(rst, ld, val, st, pa);
    checkOutput("oQ", 32'(oQ), 32'(toBcd(mCount)));
    checkOutput("oBusy", 32'(oBusy), 32'(mBusy));
    checkOutput("oDone", 32'(oDone), 32'(mDone));
    checkOutput("oDigitSel", 32'(oDigitSel), 32'(mSel));
    checkOutput("oDisplay", 32'(oDisplay), 32'(mDisp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    $display("[TB] countdown_timer bench start");

    // Reset values
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(3);

    // Full run from 12 down to 00
    applyStimulus(1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(52);

    // Borrow from tens: 10 -> 09, display alternates 3F / 6F
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(12);

    // Pause mid-step, hold, resume
    applyStimulus(1'b0, 1'b1, 8'h05, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(5);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(20);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(25);

    // Clamp on load, then start from zero
    applyStimulus(1'b0, 1'b1, 8'hAF, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(3);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Load during run ignored, reset mid-run, load beats start
    applyStimulus(1'b0, 1'b1, 8'h09, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(6);
    applyStimulus(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    idle(3);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b1, 8'h42, 1'b1, 1'b0);
    idle(5);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 299) == 0,
                    $urandom_range(0, 39) == 0,
                    8'($urandom),
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 14) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
